// File: rtl/plic_gateway.sv
// Interrupt gateway in front of the PLIC core: synchronizes raw lines, applies
// level/edge semantics and holds each source off until the PLIC completes it.
module plic_gateway #(
  parameter int IRQ_TOTAL   = 73,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_CNT_W  = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [IRQ_TOTAL-1:0] i_irq,
  input  logic [IRQ_TOTAL-1:0] i_edge_mode,
  input  logic                 i_claim_valid,
  input  logic [9:0]           i_claim_id,
  input  logic                 i_complete_valid,
  input  logic [9:0]           i_complete_id,
  output logic [IRQ_TOTAL-1:0] o_pending,
  output logic [IRQ_TOTAL-1:0] o_active,
  output logic                 o_irq_any
);

  // state | meaning
  // IDLE  | nothing outstanding, watching the line
  // PEND  | request presented to the PLIC
  // CLAIM | claimed by the PLIC, waiting for completion
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_CLAIM = 2'd2
  } gw_state_e;

  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

  logic [IRQ_TOTAL-1:0]  sync_q [SYNC_STAGES];
  logic [IRQ_TOTAL-1:0]  s_dly_q;
  logic [IRQ_TOTAL-1:0]  sync_s;
  logic [IRQ_TOTAL-1:0]  edge_s;
  gw_state_e             state_q [IRQ_TOTAL];
  gw_state_e             state_d [IRQ_TOTAL];
  logic [EDGE_CNT_W-1:0] cnt_q   [IRQ_TOTAL];
  logic [EDGE_CNT_W-1:0] cnt_d   [IRQ_TOTAL];

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign edge_s = sync_s & ~s_dly_q;

  // Callers only request a decrement when the count is non-zero.
  function automatic logic [EDGE_CNT_W-1:0] cnt_step(input logic [EDGE_CNT_W-1:0] cnt,
                                                     input logic inc, input logic dec);
    logic [EDGE_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{EDGE_CNT_W{1'b0}}, inc} - {{EDGE_CNT_W{1'b0}}, dec};
    if (sum[EDGE_CNT_W]) return CNT_MAX;
    return sum[EDGE_CNT_W-1:0];
  endfunction

  always_comb begin
    for (int n = 0; n < IRQ_TOTAL; n++) begin : g_next
      logic claim_hit;
      logic cmpl_hit;
      logic e;
      state_d[n] = state_q[n];
      cnt_d[n]   = cnt_q[n];
      claim_hit  = i_claim_valid && (i_claim_id == 10'(n));
      cmpl_hit   = i_complete_valid && (i_complete_id == 10'(n));
      e          = edge_s[n] & i_edge_mode[n];
      case (state_q[n])
        ST_IDLE: begin
          if (i_edge_mode[n] ? e : sync_s[n]) state_d[n] = ST_PEND;
          cnt_d[n] = '0;
        end
        ST_PEND: begin
          if (claim_hit) state_d[n] = ST_CLAIM;
          cnt_d[n] = cnt_step(cnt_q[n], e, 1'b0);
        end
        ST_CLAIM: begin
          if (cmpl_hit)
            state_d[n] = (i_edge_mode[n] && ((cnt_q[n] != '0) || e)) ? ST_PEND : ST_IDLE;
          cnt_d[n] = cnt_step(cnt_q[n], e, cmpl_hit && (cnt_q[n] != '0));
        end
        default: begin
          state_d[n] = ST_IDLE;
          cnt_d[n]   = '0;
        end
      endcase
      if (!i_edge_mode[n]) cnt_d[n] = '0;
    end
    state_d[0] = ST_IDLE;
    cnt_d[0]   = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_dly_q <= '0;
      for (int n = 0; n < IRQ_TOTAL; n++) begin
        state_q[n] <= ST_IDLE;
        cnt_q[n]   <= '0;
      end
    end else begin
      sync_q[0] <= i_irq;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_dly_q <= sync_s;
      for (int n = 0; n < IRQ_TOTAL; n++) begin
        state_q[n] <= state_d[n];
        cnt_q[n]   <= cnt_d[n];
      end
    end
  end

  always_comb begin
    o_pending = '0;
    o_active  = '0;
    for (int n = 0; n < IRQ_TOTAL; n++) begin
      o_pending[n] = (state_q[n] == ST_PEND);
      o_active[n]  = (state_q[n] == ST_CLAIM);
    end
  end

  assign o_irq_any = |o_pending;

endmodule

// File: tb/tb_plic_gateway.sv
// Bench for plic_gateway: vector table, directed multi-cycle sequences and a
// randomized run compared every cycle against a behavioural gateway model.
module tb_plic_gateway;
  localparam int NSRC = 73;
  localparam int SYNC = 2;
  localparam int CMAX = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] irq;
  logic [NSRC-1:0] mode;
  logic            cv, pv;
  logic [9:0]      cid, pid;
  logic [NSRC-1:0] o_pending, o_active;
  logic            o_irq_any;

  always #5 clk = ~clk;

  plic_gateway #(.IRQ_TOTAL(NSRC), .SYNC_STAGES(SYNC), .EDGE_CNT_W(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_irq(irq), .i_edge_mode(mode),
    .i_claim_valid(cv), .i_claim_id(cid),
    .i_complete_valid(pv), .i_complete_id(pid),
    .o_pending(o_pending), .o_active(o_active), .o_irq_any(o_irq_any)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: line history (newest first), per-source phase 0=idle 1=pending 2=claimed, queued edges.
  logic [NSRC-1:0] hist[$];
  int m_st  [NSRC];
  int m_cnt [NSRC];

  typedef struct {
    bit irq5; bit cv; int cid; bit pv; int pid; bit ep; bit ea;
  } vec_t;
  vec_t tbl [20];

  function automatic vec_t mk(bit a, bit b, int c, bit d, int e, bit f, bit g);
    vec_t v;
    v.irq5 = a; v.cv = b; v.cid = c; v.pv = d; v.pid = e; v.ep = f; v.ea = g;
    return v;
  endfunction

  task automatic chk_vec(string name, logic [NSRC-1:0] act, logic [NSRC-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [NSRC-1:0] s, sp;
    bit e, ch, dh;
    int c;
    if (rst) begin
      hist.delete();
      for (int i = 0; i <= SYNC; i++) hist.push_back('0);
      for (int n = 0; n < NSRC; n++) begin m_st[n] = 0; m_cnt[n] = 0; end
    end else begin
      s  = hist[SYNC-1];
      sp = hist[SYNC];
      for (int n = 1; n < NSRC; n++) begin
        e  = mode[n] && s[n] && !sp[n];
        ch = cv && (int'(cid) == n);
        dh = pv && (int'(pid) == n);
        c  = m_cnt[n];
        case (m_st[n])
          0: begin
            if (mode[n] ? e : s[n]) m_st[n] = 1;
            c = 0;
          end
          1: begin
            if (ch) m_st[n] = 2;
            c = c + int'(e);
          end
          default: begin
            if (dh) m_st[n] = (mode[n] && (c > 0 || e)) ? 1 : 0;
            c = c + int'(e) - int'(dh && c > 0);
          end
        endcase
        if (c > CMAX) c = CMAX;
        if (!mode[n]) c = 0;
        m_cnt[n] = c;
      end
      hist.push_front(irq);
      void'(hist.pop_back());
    end
  endtask

  task automatic check_model(string tag);
    logic [NSRC-1:0] ep, ea;
    ep = '0;
    ea = '0;
    for (int n = 0; n < NSRC; n++) begin
      ep[n] = (m_st[n] == 1);
      ea[n] = (m_st[n] == 2);
    end
    chk_vec({tag, "_pending"}, o_pending, ep);
    chk_vec({tag, "_active"}, o_active, ea);
    chk_bit({tag, "_any"}, o_irq_any, |ep);
  endtask

  task automatic cycle(string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic idle_bus();
    cv = 1'b0; pv = 1'b0; cid = '0; pid = '0;
  endtask

  initial begin
    rst = 1'b1; irq = '1; mode = '0;
    idle_bus();

    // Reset with every line high in level mode
    for (int i = 0; i < 3; i++) begin
      cycle("rst");
      chk_vec("rst_pending_zero", o_pending, '0);
    end
    rst = 1'b0;
    cycle("rel0");
    chk_vec("rel0_pending", o_pending, '0);
    cycle("rel1");
    chk_vec("rel1_pending", o_pending, '0);
    cycle("rel2");
    chk_vec("rel2_pending_all", o_pending, {{(NSRC-1){1'b1}}, 1'b0});

    irq = '0; rst = 1'b1;
    cycle("clr");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle("clr_idle");

    // Level path, illegal IDs, re-pend on source 5
    tbl[0]  = mk(1, 0, 0,   0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0,   0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0,   0, 0, 1, 0);
    tbl[3]  = mk(1, 1, 0,   0, 0, 1, 0);
    tbl[4]  = mk(1, 1, 100, 0, 0, 1, 0);
    tbl[5]  = mk(1, 0, 0,   1, 5, 1, 0);
    tbl[6]  = mk(1, 1, 5,   0, 0, 0, 1);
    tbl[7]  = mk(0, 1, 5,   0, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0,   1, 5, 0, 0);
    tbl[9]  = mk(0, 0, 0,   0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0,   0, 0, 0, 0);
    tbl[11] = mk(1, 0, 0,   0, 0, 0, 0);
    tbl[12] = mk(1, 0, 0,   0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0,   0, 0, 1, 0);
    tbl[14] = mk(1, 1, 5,   0, 0, 0, 1);
    tbl[15] = mk(1, 0, 0,   1, 5, 0, 0);
    tbl[16] = mk(1, 0, 0,   0, 0, 1, 0);
    tbl[17] = mk(0, 1, 5,   0, 0, 0, 1);
    tbl[18] = mk(0, 0, 0,   1, 5, 0, 0);
    tbl[19] = mk(0, 0, 0,   0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      irq = '0;
      irq[5] = tbl[i].irq5;
      cv = tbl[i].cv; cid = 10'(tbl[i].cid);
      pv = tbl[i].pv; pid = 10'(tbl[i].pid);
      cycle("tbl");
      chk_bit($sformatf("tbl%0d_pend5", i), o_pending[5], tbl[i].ep);
      chk_bit($sformatf("tbl%0d_act5", i), o_active[5], tbl[i].ea);
      chk_bit($sformatf("tbl%0d_any", i), o_irq_any, tbl[i].ep);
    end
    idle_bus();

    // Edge queue: four pulses on source 9, claim after the first
    mode[9] = 1'b1;
    cycle("mode9");
    for (int c = 0; c < 16; c++) begin
      irq[9] = (c % 4 == 0);
      cv = (c == 3); cid = 10'd9;
      cycle("edgeq");
    end
    idle_bus(); irq[9] = 1'b0;
    chk_bit("edgeq_active9", o_active[9], 1'b1);
    for (int r = 0; r < 4; r++) begin
      pv = 1'b1; pid = 10'd9;
      cycle("edgeq_cmpl");
      idle_bus();
      chk_bit($sformatf("edgeq_round%0d_pend9", r), o_pending[9], r < 3);
      if (r < 3) begin
        cv = 1'b1; cid = 10'd9;
        cycle("edgeq_claim");
        idle_bus();
        chk_bit($sformatf("edgeq_round%0d_act9", r), o_active[9], 1'b1);
      end
    end
    chk_bit("edgeq_idle_act9", o_active[9], 1'b0);

    // Saturation: ten edges while claimed
    for (int c = 0; c < 4; c++) begin
      irq[9] = (c == 0);
      cv = (c == 3); cid = 10'd9;
      cycle("sat_claim");
    end
    idle_bus();
    for (int c = 0; c < 24; c++) begin
      irq[9] = (c < 20) && (c % 2 == 0);
      cycle("sat_edges");
    end
    for (int r = 0; r < 8; r++) begin
      pv = 1'b1; pid = 10'd9;
      cycle("sat_cmpl");
      idle_bus();
      chk_bit($sformatf("sat_round%0d_pend9", r), o_pending[9], r < 7);
      if (r < 7) begin
        cv = 1'b1; cid = 10'd9;
        cycle("sat_claim");
        idle_bus();
      end
    end
    chk_bit("sat_final_act9", o_active[9], 1'b0);

    // Simultaneous claim/complete on different and identical IDs
    irq[3] = 1'b1; irq[7] = 1'b1;
    for (int c = 0; c < 3; c++) cycle("sim_rise");
    cv = 1'b1; cid = 10'd7;
    cycle("sim_claim7");
    idle_bus(); irq[3] = 1'b0; irq[7] = 1'b0;
    for (int c = 0; c < 3; c++) cycle("sim_drop");
    chk_bit("level_held_pend3", o_pending[3], 1'b1);
    cv = 1'b1; cid = 10'd3; pv = 1'b1; pid = 10'd7;
    cycle("sim_both");
    chk_bit("sim_act3", o_active[3], 1'b1);
    chk_bit("sim_act7", o_active[7], 1'b0);
    chk_bit("sim_pend7", o_pending[7], 1'b0);
    cv = 1'b1; cid = 10'd3; pv = 1'b1; pid = 10'd3;
    cycle("sim_same");
    chk_bit("same_id_act3", o_active[3], 1'b0);
    chk_bit("same_id_pend3", o_pending[3], 1'b0);
    idle_bus();
    pv = 1'b1; pid = 10'd11;
    cycle("cmpl_idle");
    chk_vec("cmpl_idle_pending", o_pending, '0);
    chk_vec("cmpl_idle_active", o_active, '0);
    idle_bus();

    // Complete coinciding with a fresh edge and an empty queue
    for (int c = 0; c < 4; c++) begin
      irq[9] = (c == 0);
      cv = (c == 3); cid = 10'd9;
      cycle("ce_claim");
    end
    idle_bus();
    cycle("ce_wait");
    irq[9] = 1'b1;
    cycle("ce_pulse");
    irq[9] = 1'b0;
    cycle("ce_gap");
    pv = 1'b1; pid = 10'd9;
    cycle("ce_cmpl");
    idle_bus();
    chk_bit("cmpl_edge_pend9", o_pending[9], 1'b1);
    for (int k = 0; k < 10; k++) begin
      idle_bus();
      if (m_st[9] == 1) begin cv = 1'b1; cid = 10'd9; end
      else if (m_st[9] == 2) begin pv = 1'b1; pid = 10'd9; end
      cycle("ce_drain");
    end
    idle_bus();
    chk_bit("ce_drained_act9", o_active[9], 1'b0);
    chk_bit("ce_drained_pend9", o_pending[9], 1'b0);

    // Randomized run against the model
    for (int n = 0; n < NSRC; n++) mode[n] = 1'($urandom_range(0, 1));
    for (int t = 0; t < 3000; t++) begin
      idle_bus();
      rst = ($urandom_range(0, 399) == 0);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        int b;
        b = $urandom_range(1, NSRC - 1);
        irq[b] = ~irq[b];
      end
      if (t % 700 == 699) begin
        int b;
        b = $urandom_range(1, NSRC - 1);
        mode[b] = ~mode[b];
      end
      cv = 1'($urandom_range(0, 1)); cid = 10'($urandom_range(0, 127));
      pv = 1'($urandom_range(0, 1)); pid = 10'($urandom_range(0, 127));
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
